// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch slice:
//   RESET_VECTOR  - default first fetch address after reset
//   NOP_INSTR     - word presented in place of an instruction that was never
//                   fetched (misaligned PC when FETCH_ADEL_CHECK_EN is defined)
//   fetch_state_t - request/response state of the fetch unit
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ADDR = 2'd1,
      WAIT_DATA = 2'd2,
      FULL      = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_inst_buffer.sv
// ---------------------------------------------------------------------------
// fetch_inst_buffer
// One-entry holding register for the instruction presented to decode.
// Parameters:
//   RESET_PC    - value of the held pc while in reset
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   i_load      - capture i_pc/i_instr (and i_exc) and mark the entry valid
//   i_consume   - decode has taken the entry; mark it empty
//   i_flush     - redirect in progress; mark it empty (wins over i_load)
//   i_pc        - address of the word being loaded
//   i_instr     - instruction word being loaded
//   o_pc        - held address
//   o_instr     - held instruction word
//   o_valid     - entry holds an instruction decode has not yet taken
// Configuration macro FETCH_ADEL_CHECK_EN adds i_exc/o_exc, an address-error
// tag that travels with the entry.
// ---------------------------------------------------------------------------
module fetch_inst_buffer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_consume,
   input  logic        i_flush,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
`ifdef FETCH_ADEL_CHECK_EN
   input  logic        i_exc,
   output logic        o_exc,
`endif
   output logic [31:0] o_pc,
   output logic [31:0] o_instr,
   output logic        o_valid
);

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_valid;
`ifdef FETCH_ADEL_CHECK_EN
   logic        r_exc;
`endif

   // A flush only drops the valid bit; the stale pc/instr remain visible but
   // are meaningless while o_valid is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
`ifdef FETCH_ADEL_CHECK_EN
         r_exc   <= 1'b0;
`endif
      end else if (i_flush) begin
         r_valid <= 1'b0;
`ifdef FETCH_ADEL_CHECK_EN
         r_exc   <= 1'b0;
`endif
      end else if (i_load) begin
         r_pc    <= i_pc;
         r_instr <= i_instr;
         r_valid <= 1'b1;
`ifdef FETCH_ADEL_CHECK_EN
         r_exc   <= i_exc;
`endif
      end else if (i_consume) begin
         r_valid <= 1'b0;
      end
   end

   assign o_pc    = r_pc;
   assign o_instr = r_instr;
   assign o_valid = r_valid;
`ifdef FETCH_ADEL_CHECK_EN
   assign o_exc   = r_exc;
`endif

endmodule

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// Fetch stage: owns the PC, issues one request at a time on an SRAM-like
// instruction port, buffers the returned word and presents it to decode
// until it is consumed. Branch redirects take effect when the delay slot is
// consumed; exception redirects take effect immediately.
// Parameters:
//   RESET_PC        - first fetch address after reset
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   stallF          - decode is not taking the presented instruction
//   branch_takenD   - branch in decode resolves taken
//   branch_targetD  - target of that branch
//   is_branchD      - decode holds a branch; presented word is its delay slot
//   exc_flush       - exception/eret redirect
//   exc_pc          - redirect address
//   inst_req/inst_addr                - request to instruction memory
//   inst_addr_ok/inst_data_ok/inst_rdata - memory handshake and read data
//   pcF, pc_plus4F, instrF, instr_validF - presented instruction
//   F_change        - presented instruction is a delay slot
//   fetch_stall     - no valid instruction presented
//   excF            - (FETCH_ADEL_CHECK_EN only) presented word is an AdEL NOP
// Configuration macro: FETCH_ADEL_CHECK_EN enables the misaligned-PC check.
// ---------------------------------------------------------------------------
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallF,
   input  logic        branch_takenD,
   input  logic [31:0] branch_targetD,
   input  logic        is_branchD,
   input  logic        exc_flush,
   input  logic [31:0] exc_pc,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [31:0] pcF,
   output logic [31:0] pc_plus4F,
   output logic [31:0] instrF,
   output logic        instr_validF,
   output logic        F_change,
`ifdef FETCH_ADEL_CHECK_EN
   output logic        excF,
`endif
   output logic        fetch_stall
);

   fetch_state_t r_state;
   fetch_state_t w_nextState;
   logic [31:0]  r_pc;
   logic [31:0]  w_nextPc;
   logic         r_discard;
   logic         w_nextDiscard;

   logic         w_bufLoad;
   logic         w_bufConsume;
   logic         w_bufFlush;
   logic [31:0]  w_bufInstr;
   logic [31:0]  w_bufPc;
   logic         w_bufValid;
   logic         w_reqAccepted;
`ifdef FETCH_ADEL_CHECK_EN
   logic         w_misaligned;
   logic         w_bufExc;

   assign w_misaligned = (r_pc[1:0] != 2'b00);
`endif

   // A request is live in IDLE and WAIT_ADDR; it is forced low while reset is
   // held so memory never sees a request before the unit is running. The
   // address is always the architectural pc, which only changes on consume
   // or flush, so it stays stable while waiting for acceptance.
`ifdef FETCH_ADEL_CHECK_EN
   assign inst_req = ~rst & (((r_state == IDLE) & ~w_misaligned) |
                             (r_state == WAIT_ADDR));
`else
   assign inst_req = ~rst & ((r_state == IDLE) | (r_state == WAIT_ADDR));
`endif
   assign inst_addr     = r_pc;
   assign w_reqAccepted = inst_req & inst_addr_ok;

   // State, pc and discard flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pc      <= RESET_PC;
         r_discard <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_pc      <= w_nextPc;
         r_discard <= w_nextDiscard;
      end
   end

   // Next-state logic. A flush overrides everything: the pc jumps to exc_pc
   // and the buffer empties. If a request is already in flight (accepted
   // earlier, or accepted right now) its data must still be absorbed, so the
   // unit waits in WAIT_DATA with discard set; a request that was never
   // accepted is simply withdrawn.
   always_comb begin
      w_nextState   = r_state;
      w_nextPc      = r_pc;
      w_nextDiscard = r_discard;
      w_bufLoad     = 1'b0;
      w_bufConsume  = 1'b0;
      w_bufFlush    = 1'b0;
      w_bufInstr    = inst_rdata;
`ifdef FETCH_ADEL_CHECK_EN
      w_bufExc      = 1'b0;
`endif
      if (exc_flush) begin
         w_nextPc   = exc_pc;
         w_bufFlush = 1'b1;
         case (r_state)
            IDLE, WAIT_ADDR: begin
               if (w_reqAccepted) begin
                  w_nextState   = WAIT_DATA;
                  w_nextDiscard = 1'b1;
               end else begin
                  w_nextState   = IDLE;
                  w_nextDiscard = 1'b0;
               end
            end
            WAIT_DATA: begin
               if (inst_data_ok) begin
                  w_nextState   = IDLE;
                  w_nextDiscard = 1'b0;
               end else begin
                  w_nextDiscard = 1'b1;
               end
            end
            default: begin
               w_nextState = IDLE;
            end
         endcase
      end else begin
         case (r_state)
            IDLE: begin
`ifdef FETCH_ADEL_CHECK_EN
               if (w_misaligned) begin
                  w_bufLoad   = 1'b1;
                  w_bufInstr  = NOP_INSTR;
                  w_bufExc    = 1'b1;
                  w_nextState = FULL;
               end else if (w_reqAccepted) begin
                  w_nextState = WAIT_DATA;
               end else begin
                  w_nextState = WAIT_ADDR;
               end
`else
               if (w_reqAccepted) begin
                  w_nextState = WAIT_DATA;
               end else begin
                  w_nextState = WAIT_ADDR;
               end
`endif
            end
            WAIT_ADDR: begin
               if (w_reqAccepted) begin
                  w_nextState = WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (inst_data_ok) begin
                  if (r_discard) begin
                     w_nextState   = IDLE;
                     w_nextDiscard = 1'b0;
                  end else begin
                     w_bufLoad   = 1'b1;
                     w_nextState = FULL;
                  end
               end
            end
            default: begin
               if (!stallF) begin
                  w_bufConsume = 1'b1;
                  w_nextPc     = branch_takenD ? branch_targetD : r_pc + 32'd4;
                  w_nextState  = IDLE;
               end
            end
         endcase
      end
   end

   fetch_inst_buffer #(
      .RESET_PC (RESET_PC)
   ) u_buffer (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_bufLoad),
      .i_consume (w_bufConsume),
      .i_flush   (w_bufFlush),
      .i_pc      (r_pc),
      .i_instr   (w_bufInstr),
`ifdef FETCH_ADEL_CHECK_EN
      .i_exc     (w_bufExc),
      .o_exc     (excF),
`endif
      .o_pc      (w_bufPc),
      .o_instr   (instrF),
      .o_valid   (w_bufValid)
   );

   assign pcF          = w_bufPc;
   assign pc_plus4F    = w_bufPc + 32'd4;
   assign instr_validF = w_bufValid;
   assign F_change     = is_branchD & w_bufValid;
   assign fetch_stall  = ~w_bufValid;

endmodule
